// File: rtl/count_event_pkg.sv
// rtl/count_event_pkg.sv - shared record types for the count event queue
package count_event_pkg;

   localparam int SEQ_W = 8;
   localparam int REC_W = 32;

   typedef enum logic [1:0] {
      EV_MATCH = 2'b01,
      EV_WRAP  = 2'b10,
      EV_BOTH  = 2'b11
   } ev_kind_t;

   typedef struct packed {
      ev_kind_t            kind;
      logic [REC_W-1:0]    stamp;
      logic [SEQ_W-1:0]    seq;
   } ev_rec_t;

endpackage

// File: rtl/count_event_queue_fifo.sv
// rtl/count_event_queue_fifo.sv - synchronous FIFO of event records
import count_event_pkg::*;

module event_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  ev_rec_t                  din,
   output ev_rec_t                  dout,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;

   ev_rec_t         mem [DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic            do_push;
   logic            do_pop;

   assign full    = (level == LW'(DEPTH));
   assign empty   = (level == '0);
   // A push while full is only taken when the head leaves in the same cycle.
   assign do_push = push && (!full || pop);
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + PW'(1);
         end
         if (do_pop)
            rd_ptr <= rd_ptr + PW'(1);
         if (do_push && !do_pop)
            level <= level + LW'(1);
         else if (do_pop && !do_push)
            level <= level - LW'(1);
      end
   end

endmodule

// File: rtl/count_event_queue.sv
// rtl/count_event_queue.sv - compare/wrap event detector feeding a record FIFO
import count_event_pkg::*;

module count_event_queue #(
   parameter int WIDTH     = 32,
   parameter int MAX_VALUE = 10000,
   parameter int DEPTH     = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [WIDTH-1:0]         count_i,
   input  logic                     cmp_we,
   input  logic [WIDTH-1:0]         cmp_wdata,
   input  logic                     cmp_en,
   output logic                     ev_valid,
   input  logic                     ev_ready,
   output logic [1:0]               ev_kind,
   output logic [WIDTH-1:0]         ev_stamp,
   output logic [7:0]               ev_seq,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow,
   input  logic                     clr_overflow
);

   localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VALUE);

   logic [WIDTH-1:0]   cmp_reg;
   logic [WIDTH-1:0]   prev_count;
   logic               prev_valid;
   logic [SEQ_W-1:0]   seq_ctr;
   logic               chg;
   logic               match;
   logic               wrap;
   logic               event_hit;
   logic               pop;
   logic               drop;
   logic               full;
   logic               empty;
   ev_rec_t            rec_in;
   ev_rec_t            head;

   // A stalled counter must yield a single event, hence the change qualifier.
   assign chg       = !prev_valid || (count_i != prev_count);
   assign match     = chg && cmp_en && (count_i == cmp_reg);
   assign wrap      = chg && prev_valid && (prev_count == MAX_W) && (count_i == '0);
   assign event_hit = match || wrap;
   assign pop       = ev_ready && !empty;
   assign drop      = event_hit && full && !pop;

   assign rec_in.kind  = ev_kind_t'({wrap, match});
   assign rec_in.stamp = REC_W'(count_i);
   assign rec_in.seq   = seq_ctr;

   always_ff @(posedge clk) begin
      if (rst) begin
         cmp_reg    <= '0;
         prev_count <= '0;
         prev_valid <= 1'b0;
         seq_ctr    <= '0;
         overflow   <= 1'b0;
      end else begin
         if (cmp_we)
            cmp_reg <= cmp_wdata;
         prev_count <= count_i;
         prev_valid <= 1'b1;
         if (event_hit)
            seq_ctr <= seq_ctr + SEQ_W'(1);
         if (drop)
            overflow <= 1'b1;
         else if (clr_overflow)
            overflow <= 1'b0;
      end
   end

   event_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (event_hit),
      .pop   (pop),
      .din   (rec_in),
      .dout  (head),
      .level (level),
      .full  (full),
      .empty (empty)
   );

   // Fields read as zero while empty so stale memory never leaks out.
   assign ev_valid = !empty;
   assign ev_kind  = empty ? 2'b00 : head.kind;
   assign ev_stamp = empty ? '0 : WIDTH'(head.stamp);
   assign ev_seq   = empty ? '0 : head.seq;

endmodule

// File: tb/tb_count_event_queue.sv
// tb/tb_count_event_queue.sv - directed self-checking bench for count_event_queue
module tb_count_event_queue;

   logic          clk = 1'b0;
   logic          rst;
   logic [31:0]   count_i;
   logic          cmp_we;
   logic [31:0]   cmp_wdata;
   logic          cmp_en;
   logic          ev_valid;
   logic          ev_ready;
   logic [1:0]    ev_kind;
   logic [31:0]   ev_stamp;
   logic [7:0]    ev_seq;
   logic [2:0]    level;
   logic          overflow;
   logic          clr_overflow;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   count_event_queue #(.WIDTH(32), .MAX_VALUE(10), .DEPTH(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .count_i      (count_i),
      .cmp_we       (cmp_we),
      .cmp_wdata    (cmp_wdata),
      .cmp_en       (cmp_en),
      .ev_valid     (ev_valid),
      .ev_ready     (ev_ready),
      .ev_kind      (ev_kind),
      .ev_stamp     (ev_stamp),
      .ev_seq       (ev_seq),
      .level        (level),
      .overflow     (overflow),
      .clr_overflow (clr_overflow)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock cycle: inputs applied just after the edge, outputs left for sampling at the falling edge.
   task automatic cyc(input logic r, input logic [31:0] c, input logic en, input logic rdy,
                      input logic clr, input logic we, input logic [31:0] wd);
      @(posedge clk);
      #1;
      rst          = r;
      count_i      = c;
      cmp_en       = en;
      ev_ready     = rdy;
      clr_overflow = clr;
      cmp_we       = we;
      cmp_wdata    = wd;
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; count_i = '0; cmp_we = 1'b0; cmp_wdata = '0;
      cmp_en = 1'b0; ev_ready = 1'b0; clr_overflow = 1'b0;

      // Reset state
      cyc(1, 0, 1, 1, 0, 0, 0);
      cyc(1, 0, 1, 1, 0, 0, 0);
      check("rst_valid", ev_valid, 0);
      check("rst_level", level, 0);
      check("rst_ovf", overflow, 0);
      check("rst_kind", ev_kind, 0);
      check("rst_stamp", ev_stamp, 0);
      check("rst_seq", ev_seq, 0);

      // Compare match at 5
      for (int k = 1; k <= 8; k++) begin
         cyc(0, k, 1, 1, 0, (k == 1), 5);
         check($sformatf("m_valid_%0d", k), ev_valid, (k == 6));
         if (k == 6) begin
            check("m_kind", ev_kind, 2'b01);
            check("m_stamp", ev_stamp, 5);
            check("m_seq", ev_seq, 0);
         end
      end

      // Wrap coinciding with match, then wrap alone
      for (int pass = 0; pass < 2; pass++) begin
         cyc(1, 0, 1, 1, 0, 0, 0);
         cyc(0, 9, (pass == 0), 1, 0, 0, 0);  check("w_v9", ev_valid, 0);
         cyc(0, 10, (pass == 0), 1, 0, 0, 0); check("w_v10", ev_valid, 0);
         cyc(0, 0, (pass == 0), 1, 0, 0, 0);  check("w_v0", ev_valid, 0);
         cyc(0, 1, (pass == 0), 1, 0, 0, 0);
         check("w_valid", ev_valid, 1);
         check("w_kind", ev_kind, (pass == 0) ? 2'b11 : 2'b10);
         check("w_stamp", ev_stamp, 0);
         check("w_seq", ev_seq, 0);
         cyc(0, 2, (pass == 0), 1, 0, 0, 0);  check("w_v2", ev_valid, 0);
      end

      // Stalled counter gives one record
      cyc(1, 0, 1, 0, 0, 0, 0);
      cyc(0, 4, 1, 0, 0, 1, 5);
      check("s_v4", ev_valid, 0);
      for (int k = 0; k < 10; k++)
         cyc(0, 5, 1, 0, 0, 0, 0);
      check("s_level", level, 1);
      check("s_valid", ev_valid, 1);
      check("s_stamp", ev_stamp, 5);
      check("s_seq", ev_seq, 0);

      // Six events into four entries, then drain
      cyc(1, 0, 1, 0, 0, 0, 0);
      for (int i = 0; i < 12; i++)
         cyc(0, i % 2, 1, 0, 0, 0, 0);
      cyc(0, 1, 1, 0, 0, 0, 0);
      check("f_level", level, 4);
      check("f_ovf", overflow, 1);
      check("f_head", ev_seq, 0);
      for (int j = 0; j < 4; j++) begin
         cyc(0, 1, 1, 1, 0, 0, 0);
         check($sformatf("d_valid_%0d", j), ev_valid, 1);
         check($sformatf("d_seq_%0d", j), ev_seq, j);
      end
      cyc(0, 1, 1, 0, 0, 0, 0);
      check("d_empty", ev_valid, 0);
      check("d_level", level, 0);
      cyc(0, 0, 1, 0, 0, 0, 0);
      cyc(0, 0, 1, 0, 1, 0, 0);
      check("n_valid", ev_valid, 1);
      check("n_seq", ev_seq, 6);
      check("n_kind", ev_kind, 2'b01);

      // Push and pop while full; then clear racing a drop
      cyc(0, 1, 1, 0, 0, 0, 0);
      check("c_ovf_clr", overflow, 0);
      cyc(0, 0, 1, 0, 0, 0, 0);
      cyc(0, 1, 1, 0, 0, 0, 0);
      cyc(0, 0, 1, 0, 0, 0, 0);
      cyc(0, 1, 1, 0, 0, 0, 0);
      cyc(0, 0, 1, 0, 0, 0, 0);
      cyc(0, 1, 1, 0, 0, 0, 0);
      check("c_full", level, 4);
      cyc(0, 0, 1, 1, 0, 0, 0);
      check("c_head_pre", ev_seq, 6);
      cyc(0, 1, 1, 0, 0, 0, 0);
      check("c_level", level, 4);
      check("c_ovf", overflow, 0);
      check("c_head", ev_seq, 7);
      cyc(0, 0, 1, 0, 1, 0, 0);
      cyc(0, 1, 1, 0, 0, 0, 0);
      check("c_ovf_set", overflow, 1);
      check("c_level2", level, 4);
      check("c_head2", ev_seq, 7);

      // Reset discards queued records
      cyc(0, 1, 1, 1, 0, 0, 0);
      cyc(1, 1, 1, 0, 0, 0, 0);
      check("r_pre_level", level, 3);
      cyc(0, 0, 1, 0, 0, 0, 0);
      check("r_valid", ev_valid, 0);
      check("r_level", level, 0);
      check("r_ovf", overflow, 0);
      cyc(0, 1, 1, 0, 0, 0, 0);
      check("r_ev_valid", ev_valid, 1);
      check("r_ev_seq", ev_seq, 0);
      check("r_ev_kind", ev_kind, 2'b01);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
